// File: rtl/byte_serial_mem_bridge_if.sv
// Bundles the 32-bit word request port and the 8-bit physical memory port of the bridge.
// master: the requester plus backing memory; slave: the bridge itself.
interface byte_serial_mem_bridge_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic [31:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [7:0]  pmem_wdata;
    logic [7:0]  pmem_rdata;
    logic        pmem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/byte_serial_mem_bridge.sv
// Serialises 32-bit word reads/writes into byte beats on an 8-bit memory port.
// All outputs decode from registered state only.
module byte_serial_mem_bridge (
    input logic                     clk,
    input logic                     rst,
    byte_serial_mem_bridge_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [29:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  first_lane;
    logic [1:0]  next_lane;
    logic        next_valid;

    // Lowest enabled lane of the incoming mask, and lowest latched lane above idx.
    always_comb begin
        first_lane = 2'd0;
        next_lane  = idx_q;
        next_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.mem_byte_enable[i]) begin
                first_lane = 2'(i);
            end
            if (mask_q[i] && (i > int'(idx_q))) begin
                next_lane  = 2'(i);
                next_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_read) begin
                    base_d  = bus.mem_address[31:2];
                    idx_d   = 2'd0;
                    state_d = READ;
                end else if (bus.mem_write) begin
                    base_d  = bus.mem_address[31:2];
                    wdata_d = bus.mem_wdata;
                    mask_d  = bus.mem_byte_enable;
                    idx_d   = first_lane;
                    state_d = (bus.mem_byte_enable != 4'b0000) ? WRITE : DONE;
                end
            end
            READ: begin
                if (bus.pmem_resp) begin
                    rdata_d[{idx_q, 3'b000} +: 8] = bus.pmem_rdata;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                if (bus.pmem_resp) begin
                    if (next_valid) begin
                        idx_d = next_lane;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            base_q  <= 30'd0;
            wdata_q <= 32'd0;
            mask_q  <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    logic beat_active;
    assign beat_active      = (state_q == READ) || (state_q == WRITE);
    assign bus.pmem_read    = (state_q == READ);
    assign bus.pmem_write   = (state_q == WRITE);
    assign bus.pmem_address = beat_active ? {base_q, idx_q} : 32'd0;
    assign bus.pmem_wdata   = (state_q == WRITE) ? wdata_q[{idx_q, 3'b000} +: 8] : 8'd0;
    assign bus.mem_resp     = (state_q == DONE);
    assign bus.mem_rdata    = rdata_q;
endmodule

// File: tb/tb_byte_serial_mem_bridge.sv
// Directed bench for byte_serial_mem_bridge with a byte memory model that has a
// configurable per-beat wait count.
module tb_byte_serial_mem_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    byte_serial_mem_bridge_if bus ();

    byte_serial_mem_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int resp_total = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_resp) resp_total <= resp_total + 1;
    end

    logic [7:0]  mem [0:65535];
    int          wait_cfg = 0;
    logic        force_resp = 1'b0;
    logic [31:0] b_addr [0:63];
    logic [7:0]  b_data [0:63];
    logic        b_wr   [0:63];
    int          b_cyc  [0:63];
    int          nb = 0;

    // Memory model: acts at negedge on the registered strobes.
    initial begin
        int cnt;
        cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (force_resp) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = 8'hFF;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (cnt == wait_cfg) begin
                    cnt = 0;
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_read) begin
                        bus.pmem_rdata = mem[bus.pmem_address[15:0]];
                        b_data[nb]     = mem[bus.pmem_address[15:0]];
                    end else begin
                        mem[bus.pmem_address[15:0]] = bus.pmem_wdata;
                        b_data[nb] = bus.pmem_wdata;
                    end
                    b_addr[nb] = bus.pmem_address;
                    b_wr[nb]   = bus.pmem_write;
                    b_cyc[nb]  = cyc;
                    if (nb < 63) nb++;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Raise a request, wait for mem_resp (n = cycles after acceptance), drop it.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input int chg,
                          output int n);
        bus.mem_address     = addr;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == chg) bus.mem_address = 32'h0000_5000;
            if (bus.mem_resp) begin
                n = i;
                break;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        int n;
        int s;
        int r0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h1004] = 8'h11; mem[16'h1005] = 8'h22;
        mem[16'h1006] = 8'h33; mem[16'h1007] = 8'h44;
        bus.mem_address = 32'd0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.mem_byte_enable = 4'd0; bus.mem_wdata = 32'd0;

        tick(); tick();
        check("rst_rdata", bus.mem_rdata, 32'd0);
        check("rst_resp", {31'd0, bus.mem_resp}, 32'd0);
        check("rst_strobes", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
        check("rst_addr", bus.pmem_address, 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait read of an unaligned address.
        s = nb;
        do_req(1'b1, 1'b0, 32'h0000_1006, 4'b0000, 32'd0, 0, n);
        check("rd_latency", n, 5);
        check("rd_rdata", bus.mem_rdata, 32'h4433_2211);
        check("rd_beats", nb - s, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_addr%0d", i), b_addr[s+i], 32'h0000_1004 + i);
            check($sformatf("rd_cyc%0d", i), b_cyc[s+i] - b_cyc[s], i);
        end
        tick();

        // Sparse-mask write.
        s = nb;
        do_req(1'b0, 1'b1, 32'h0000_2000, 4'b1010, 32'hAABB_CCDD, 0, n);
        check("wr_latency", n, 3);
        check("wr_beats", nb - s, 2);
        check("wr_addr0", b_addr[s], 32'h0000_2001);
        check("wr_data0", {24'd0, b_data[s]}, 32'h0000_00CC);
        check("wr_flag0", {31'd0, b_wr[s]}, 32'd1);
        check("wr_addr1", b_addr[s+1], 32'h0000_2003);
        check("wr_data1", {24'd0, b_data[s+1]}, 32'h0000_00AA);
        check("wr_rdata_kept", bus.mem_rdata, 32'h4433_2211);
        tick();

        // Empty-mask write: no beats at all.
        s = nb;
        do_req(1'b0, 1'b1, 32'h0000_3000, 4'b0000, 32'h1234_5678, 0, n);
        check("wr0_latency", n, 1);
        check("wr0_beats", nb - s, 0);
        tick();

        // Two wait cycles per beat; address changed mid-transfer.
        mem[16'h1004] = 8'h55; mem[16'h1005] = 8'h66;
        mem[16'h1006] = 8'h77; mem[16'h1007] = 8'h88;
        wait_cfg = 2;
        s = nb;
        do_req(1'b1, 1'b0, 32'h0000_1004, 4'b0000, 32'd0, 6, n);
        check("rdw_latency", n, 13);
        check("rdw_beats", nb - s, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rdw_addr%0d", i), b_addr[s+i], 32'h0000_1004 + i);
            check($sformatf("rdw_cyc%0d", i), b_cyc[s+i] - b_cyc[s], 3 * i);
        end
        check("rdw_rdata", bus.mem_rdata, 32'h8877_6655);
        wait_cfg = 0;
        tick();

        // Both requests high: read wins; reset during beat 2.
        s = nb;
        bus.mem_address = 32'h0000_1004; bus.mem_byte_enable = 4'b1111;
        bus.mem_wdata = 32'hDEAD_BEEF;
        bus.mem_read = 1'b1; bus.mem_write = 1'b1;
        tick();
        check("both_b0", {bus.pmem_read, bus.pmem_write, bus.pmem_address[29:0]},
              {2'b10, 30'h1004});
        tick();
        check("both_b1", {bus.pmem_read, bus.pmem_write, bus.pmem_address[29:0]},
              {2'b10, 30'h1005});
        tick();
        check("both_b2", {bus.pmem_read, bus.pmem_write, bus.pmem_address[29:0]},
              {2'b10, 30'h1006});
        rst = 1'b1; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        tick();
        check("mrst_strobes", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
        check("mrst_addr", bus.pmem_address, 32'd0);
        check("mrst_wdata", {24'd0, bus.pmem_wdata}, 32'd0);
        check("mrst_resp", {31'd0, bus.mem_resp}, 32'd0);
        check("mrst_rdata", bus.mem_rdata, 32'd0);
        for (int i = s; i < nb; i++) check("both_no_write", {31'd0, b_wr[i]}, 32'd0);
        rst = 1'b0;
        tick(); tick();
        check("idle_after_rst", {29'd0, bus.pmem_read, bus.pmem_write, bus.mem_resp}, 32'd0);

        // Back-to-back fetch then store, then spurious pmem_resp in IDLE.
        mem[16'h1008] = 8'h01; mem[16'h1009] = 8'h02;
        mem[16'h100A] = 8'h03; mem[16'h100B] = 8'h04;
        r0 = resp_total;
        do_req(1'b1, 1'b0, 32'h0000_1008, 4'b0000, 32'd0, 0, n);
        check("b2b_rd_latency", n, 5);
        tick();
        do_req(1'b0, 1'b1, 32'h0000_4000, 4'b0001, 32'h0000_00EE, 0, n);
        check("b2b_wr_latency", n, 2);
        tick(); tick(); tick();
        check("b2b_resp_count", resp_total - r0, 2);
        check("b2b_rdata", bus.mem_rdata, 32'h0403_0201);
        check("b2b_mem", {24'd0, mem[16'h4000]}, 32'h0000_00EE);
        r0 = resp_total;
        force_resp = 1'b1;
        tick(); tick(); tick();
        force_resp = 1'b0;
        tick();
        check("spur_rdata", bus.mem_rdata, 32'h0403_0201);
        check("spur_strobes", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
        check("spur_resp", resp_total - r0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
